dram_stream_feeder: RTL and testbench
=====================================

DRAM_STREAM_FEEDER -- requirements
Module: dram_stream_feeder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the memory word-address width.
REQ-002 The block SHALL have parameter LEN_W, default 12, the load-length counter width.
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle job request.
REQ-006 src_base  input  ADDR_W  first memory word to stream.
REQ-007 load_len  input  LEN_W  number of words to stream.
REQ-008 dst_base  input  ADDR_W  first memory word for results.
REQ-009 mem_ren / mem_raddr  output  1 / ADDR_W  read port; data SHALL return one cycle after mem_ren.
REQ-010 mem_rdata  input  32  read data.
REQ-011 mem_wen / mem_waddr / mem_wdata  output  1 / ADDR_W / 32  write port.
REQ-012 acc_ready  output  1  drives the accelerator's ready; one word is transferred per cycle while it is high.
REQ-013 acc_data  output  32  word to the accelerator's data_in.
REQ-014 acc_valid / acc_ofmap / acc_done  input  1 / 32 / 1  accelerator result stream and job-done signal.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 finished  output  1  one-cycle pulse at job end.
REQ-017 wr_count  output  LEN_W  memory writes issued in the current job.

Function
REQ-018 The FSM SHALL have the states IDLE, PREFETCH, STREAM, COLLECT and DONE.
REQ-019 IDLE->PREFETCH SHALL occur on start with load_len!=0; the block SHALL latch src_base, load_len and dst_base, and clear wr_count.
REQ-020 start with load_len==0, or start in any non-IDLE state, SHALL be ignored.
REQ-021 PREFETCH SHALL last 1 cycle, assert mem_ren with mem_raddr=src_base, then go to STREAM.
REQ-022 STREAM SHALL last exactly load_len cycles with acc_ready=1.
REQ-023 In STREAM cycle k, acc_data SHALL equal mem_rdata, which is word src_base+k.
REQ-024 In STREAM cycle k, mem_ren SHALL be asserted for word src_base+k+1 only when k+1<load_len.
REQ-025 acc_ready SHALL be 0 in every state other than STREAM, and acc_data SHALL be 0 there.
REQ-026 After the last STREAM cycle, the FSM SHALL go to COLLECT.
REQ-027 In PREFETCH, STREAM and COLLECT, each cycle with acc_valid=1 SHALL produce a write to dst_base+wr_count and then increment wr_count.
REQ-028 The memory address SHALL wrap modulo 2^ADDR_W; wr_count SHALL saturate at all-ones.
REQ-029 acc_done in COLLECT SHALL cause a transition to DONE; a simultaneous acc_valid word SHALL still be written.
REQ-030 acc_done in PREFETCH or STREAM SHALL be recorded, and the FSM SHALL go directly from STREAM to DONE.
REQ-031 DONE SHALL last 1 cycle, assert finished=1, then return to IDLE.
REQ-032 wr_count SHALL hold its value until the next accepted start.

Reset
REQ-033 rst SHALL force IDLE and clear all counters and latched state.
REQ-034 During reset, all outputs (mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, acc_ready, acc_data, busy, finished, wr_count) SHALL be 0.
REQ-035 rst mid-job SHALL abort the job with no further writes and no finished pulse.

Configuration
REQ-036 With WRITEBACK_PACK_EN defined, each acc_valid SHALL contribute acc_ofmap[7:0] to a packing register, little-endian (the first byte goes to bits 7:0).
REQ-037 With WRITEBACK_PACK_EN defined, a write SHALL be issued on every 4th byte; on acc_done with a partial word pending, that word SHALL be flushed with zero-filled upper bytes before DONE.
REQ-038 Without WRITEBACK_PACK_EN, each acc_valid SHALL write the full 32-bit acc_ofmap.

Verification
REQ-039 start, src_base=0x0100, load_len=3, memory[0x100..0x102]=A,B,C -> acc_ready high for exactly 3 cycles carrying A,B,C, starting 1 cycle after PREFETCH.
REQ-040 Without WRITEBACK_PACK_EN: dst_base=0x0200, acc_valid with values 0x11 then 0x22, then acc_done -> mem[0x200]=0x11, mem[0x201]=0x22, wr_count=2, finished pulses once.
REQ-041 With WRITEBACK_PACK_EN: bytes 01,02,03,04,05 then acc_done -> mem[dst]=0x04030201, mem[dst+1]=0x00000005, wr_count=2.
REQ-042 dst_base=0xFFFF with 2 results -> writes land at 0xFFFF then 0x0000.
REQ-043 start with load_len=0 -> busy stays 0; start during STREAM -> latched values unchanged.
REQ-044 rst asserted in STREAM cycle 2 of a 5-word job -> next cycle acc_ready=0, busy=0, no writes, no finished pulse.

Source files
------------

// File: rtl/dram_stream_feeder_if.sv
`default_nettype none
// =============================================================================
// Module   : dram_stream_feeder_if
// Brief    : Job request, memory read/write port and accelerator stream signals
//            shared by the DRAM stream feeder and its environment.
// Revision : 1.0 - initial release
// =============================================================================
interface dram_stream_feeder_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
);
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [LEN_W-1:0]  load_len;
    logic [ADDR_W-1:0] dst_base;

    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    logic              acc_ready;
    logic [31:0]       acc_data;
    logic              acc_valid;
    logic [31:0]       acc_ofmap;
    logic              acc_done;

    logic              busy;
    logic              finished;
    logic [LEN_W-1:0]  wr_count;

    modport master (
        input  start, src_base, load_len, dst_base, mem_rdata,
               acc_valid, acc_ofmap, acc_done,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               acc_ready, acc_data, busy, finished, wr_count
    );

    modport slave (
        output start, src_base, load_len, dst_base, mem_rdata,
               acc_valid, acc_ofmap, acc_done,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               acc_ready, acc_data, busy, finished, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/dram_stream_feeder.sv
`default_nettype none
// =============================================================================
// Module   : dram_stream_feeder
// Brief    : Streams a block of memory words into an accelerator and writes its
//            results back; WRITEBACK_PACK_EN packs result bytes into words.
// Revision : 1.0 - initial release
// =============================================================================
module dram_stream_feeder #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_stream_feeder_if.master bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_COLLECT  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        r_state_q, w_state_d;
    logic [ADDR_W-1:0] r_src_q, w_src_d;
    logic [ADDR_W-1:0] r_dst_q, w_dst_d;
    logic [LEN_W-1:0]  r_len_q, w_len_d;
    logic [LEN_W-1:0]  r_idx_q, w_idx_d;
    logic [LEN_W-1:0]  r_wr_count_q, w_wr_count_d;
    logic              r_done_seen_q, w_done_seen_d;

    logic              w_start_ok;
    logic              w_active;
    logic              w_last_beat;
    logic              w_has_next;
    logic              w_done_evt;
    logic              w_wr_fire;
    logic [31:0]       w_wr_word;

    always_comb begin
        w_start_ok  = (r_state_q == S_IDLE) && bus.start && (bus.load_len != '0);
        w_active    = (r_state_q == S_PREFETCH) || (r_state_q == S_STREAM) ||
                      (r_state_q == S_COLLECT);
        w_last_beat = (r_state_q == S_STREAM) && (r_idx_q == (r_len_q - LEN_W'(1)));
        w_has_next  = r_idx_q < (r_len_q - LEN_W'(1));
        // Job end: done seen in COLLECT, or recorded earlier and honoured on the last beat
        w_done_evt  = ((r_state_q == S_COLLECT) && bus.acc_done) ||
                      (w_last_beat && (r_done_seen_q || bus.acc_done));
    end

`ifdef WRITEBACK_PACK_EN
    logic [23:0] r_pack_q, w_pack_d;
    logic [1:0]  r_pack_cnt_q, w_pack_cnt_d;
    logic [7:0]  w_byte;
    logic [31:0] w_merged;
    logic [2:0]  w_fill;

    always_comb begin
        w_byte       = bus.acc_valid ? bus.acc_ofmap[7:0] : 8'h00;
        w_merged     = {8'h00, r_pack_q} | ({24'h000000, w_byte} << {r_pack_cnt_q, 3'b000});
        w_fill       = {1'b0, r_pack_cnt_q} + {2'b00, bus.acc_valid};
        w_pack_d     = r_pack_q;
        w_pack_cnt_d = r_pack_cnt_q;
        w_wr_fire    = 1'b0;
        w_wr_word    = w_merged;
        if (w_start_ok) begin
            w_pack_d     = '0;
            w_pack_cnt_d = '0;
        end else if (w_active) begin
            // A done cycle can complete at most one word, so one write port suffices
            w_wr_fire = (w_fill == 3'd4) || (w_done_evt && (w_fill != 3'd0));
            if (w_wr_fire || w_done_evt) begin
                w_pack_d     = '0;
                w_pack_cnt_d = '0;
            end else if (bus.acc_valid) begin
                w_pack_d     = w_merged[23:0];
                w_pack_cnt_d = w_fill[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack_q     <= '0;
            r_pack_cnt_q <= '0;
        end else begin
            r_pack_q     <= w_pack_d;
            r_pack_cnt_q <= w_pack_cnt_d;
        end
    end
`else
    always_comb begin
        w_wr_fire = w_active && bus.acc_valid;
        w_wr_word = bus.acc_ofmap;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:     if (w_start_ok) w_state_d = S_PREFETCH;
            S_PREFETCH: w_state_d = S_STREAM;
            S_STREAM: begin
                if (w_done_evt) begin
                    w_state_d = S_DONE;
                end else if (w_last_beat) begin
                    w_state_d = S_COLLECT;
                end
            end
            S_COLLECT:  if (w_done_evt) w_state_d = S_DONE;
            S_DONE:     w_state_d = S_IDLE;
            default:    w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_src_d       = r_src_q;
        w_dst_d       = r_dst_q;
        w_len_d       = r_len_q;
        w_idx_d       = r_idx_q;
        w_wr_count_d  = r_wr_count_q;
        w_done_seen_d = r_done_seen_q;
        if (w_start_ok) begin
            w_src_d       = bus.src_base;
            w_dst_d       = bus.dst_base;
            w_len_d       = bus.load_len;
            w_idx_d       = '0;
            w_wr_count_d  = '0;
            w_done_seen_d = 1'b0;
        end
        if (r_state_q == S_STREAM) begin
            w_idx_d = r_idx_q + LEN_W'(1);
        end
        if (((r_state_q == S_PREFETCH) || (r_state_q == S_STREAM)) && bus.acc_done) begin
            w_done_seen_d = 1'b1;
        end
        if (w_wr_fire && (r_wr_count_q != '1)) begin
            w_wr_count_d = r_wr_count_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q       <= '0;
            r_dst_q       <= '0;
            r_len_q       <= '0;
            r_idx_q       <= '0;
            r_wr_count_q  <= '0;
            r_done_seen_q <= 1'b0;
        end else begin
            r_src_q       <= w_src_d;
            r_dst_q       <= w_dst_d;
            r_len_q       <= w_len_d;
            r_idx_q       <= w_idx_d;
            r_wr_count_q  <= w_wr_count_d;
            r_done_seen_q <= w_done_seen_d;
        end
    end

    // Outputs are forced low while rst is high, even before the state settles
    always_comb begin
        bus.mem_ren   = 1'b0;
        bus.mem_raddr = '0;
        bus.mem_wen   = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        bus.acc_ready = 1'b0;
        bus.acc_data  = '0;
        bus.busy      = 1'b0;
        bus.finished  = 1'b0;
        bus.wr_count  = '0;
        if (!rst) begin
            bus.busy     = (r_state_q != S_IDLE);
            bus.finished = (r_state_q == S_DONE);
            bus.wr_count = r_wr_count_q;
            case (r_state_q)
                S_PREFETCH: begin
                    bus.mem_ren   = 1'b1;
                    bus.mem_raddr = r_src_q;
                end
                S_STREAM: begin
                    bus.acc_ready = 1'b1;
                    bus.acc_data  = bus.mem_rdata;
                    if (w_has_next) begin
                        bus.mem_ren   = 1'b1;
                        bus.mem_raddr = r_src_q + ADDR_W'(r_idx_q) + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
            if (w_wr_fire) begin
                bus.mem_wen   = 1'b1;
                bus.mem_waddr = r_dst_q + ADDR_W'(r_wr_count_q);
                bus.mem_wdata = w_wr_word;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dram_stream_feeder.sv
`default_nettype none
// =============================================================================
// Module   : tb_dram_stream_feeder
// Brief    : Directed and randomized jobs against a cycle-timeline reference
//            model of the DRAM stream feeder.
// Revision : 1.0 - initial release
// =============================================================================
module tb_dram_stream_feeder;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 12;
    localparam int MAXC   = 4400;
    localparam int SAT    = 4095;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   prev_wr = 0;

    dram_stream_feeder_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut_if ();
    dram_stream_feeder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    logic [31:0] rom    [0:65535];
    logic [31:0] wr_mem [0:65535];
    logic [15:0] obs_wa [$];
    logic [31:0] obs_wd [$];
    bit          vld_a  [MAXC];
    logic [31:0] dat_a  [MAXC];

    // Memory: one-cycle read latency, writes captured in order
    always @(posedge clk) begin
        if (dut_if.mem_ren) dut_if.mem_rdata <= rom[dut_if.mem_raddr];
        if (dut_if.mem_wen) begin
            wr_mem[dut_if.mem_waddr] <= dut_if.mem_wdata;
            obs_wa.push_back(dut_if.mem_waddr);
            obs_wd.push_back(dut_if.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        dut_if.start     = 1'b0;
        dut_if.src_base  = '0;
        dut_if.load_len  = '0;
        dut_if.dst_base  = '0;
        dut_if.acc_valid = 1'b0;
        dut_if.acc_ofmap = '0;
        dut_if.acc_done  = 1'b0;
    endtask

    task automatic clear_pattern();
        for (int i = 0; i < MAXC; i++) begin
            vld_a[i] = 1'b0;
            dat_a[i] = '0;
        end
    endtask

    // Timeline: c=0 accept, c=1 prefetch, c=2..len+1 stream, then collect until done
    task automatic run_job(input logic [15:0] src, input int len, input logic [15:0] dst,
                           input int d, input bit poke, input int job);
        logic [31:0] exp_rd [$];
        logic [31:0] ed [$];
        logic [15:0] a;
        logic [31:0] w;
        int done_c, base, exp_cnt, nw;
        bit exp_busy, exp_rdy, exp_ren;
`ifdef WRITEBACK_PACK_EN
        logic [7:0] bq [$];
`endif
        for (int k = 0; k < len; k++) begin
            a = src + 16'(k);
            exp_rd.push_back(rom[a]);
        end
        done_c = (d <= len + 1) ? len + 2 : d + 1;
`ifdef WRITEBACK_PACK_EN
        for (int c = 1; c < done_c; c++) if (vld_a[c]) bq.push_back(dat_a[c][7:0]);
        for (int i = 0; i < bq.size(); i += 4) begin
            w = '0;
            for (int j = 0; j < 4; j++) if (i + j < bq.size()) w[8*j +: 8] = bq[i+j];
            ed.push_back(w);
        end
`else
        for (int c = 1; c < done_c; c++) if (vld_a[c]) ed.push_back(dat_a[c]);
`endif
        nw      = ed.size();
        exp_cnt = (nw > SAT) ? SAT : nw;
        base    = obs_wa.size();

        for (int c = 0; c <= done_c + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                dut_if.start    = 1'b1;
                dut_if.src_base = src;
                dut_if.load_len = LEN_W'(len);
                dut_if.dst_base = dst;
            end else begin
                dut_if.start    = poke && (c == 3);
                dut_if.src_base = 16'($urandom);
                dut_if.load_len = LEN_W'($urandom_range(1, 4000));
                dut_if.dst_base = 16'($urandom);
            end
            dut_if.acc_valid = vld_a[c];
            dut_if.acc_ofmap = dat_a[c];
            dut_if.acc_done  = (c == d);
            #1;
            if (c == 0) check($sformatf("wr_hold j%0d", job), 32'(dut_if.wr_count), prev_wr);
            exp_busy = (c >= 1) && (c <= done_c);
            exp_rdy  = (c >= 2) && (c <= len + 1);
            exp_ren  = (c >= 1) && (c <= len);
            check($sformatf("busy j%0d c%0d", job, c), 32'(dut_if.busy), 32'(exp_busy));
            check($sformatf("ready j%0d c%0d", job, c), 32'(dut_if.acc_ready), 32'(exp_rdy));
            check($sformatf("data j%0d c%0d", job, c), dut_if.acc_data,
                  exp_rdy ? exp_rd[c-2] : 32'h0);
            check($sformatf("fin j%0d c%0d", job, c), 32'(dut_if.finished), 32'(c == done_c));
            check($sformatf("ren j%0d c%0d", job, c), 32'(dut_if.mem_ren), 32'(exp_ren));
            if (exp_ren) begin
                a = src + 16'(c - 1);
                check($sformatf("raddr j%0d c%0d", job, c), 32'(dut_if.mem_raddr), 32'(a));
            end
        end
        check($sformatf("wr_count j%0d", job), 32'(dut_if.wr_count), exp_cnt);
        check($sformatf("nwrites j%0d", job), obs_wa.size() - base, nw);
        for (int i = 0; i < nw; i++) begin
            if (base + i < obs_wa.size()) begin
                a = dst + 16'((i > SAT) ? SAT : i);
                check($sformatf("waddr j%0d w%0d", job, i), 32'(obs_wa[base+i]), 32'(a));
                check($sformatf("wdata j%0d w%0d", job, i), obs_wd[base+i], ed[i]);
            end
        end
        prev_wr = exp_cnt;
        idle_inputs();
    endtask

    initial begin
        int len, d, base;
        logic [15:0] src, dst;
        bit poke;

        idle_inputs();
        for (int i = 0; i < 65536; i++) rom[i] = $urandom;
        rom[16'h0100] = 32'hA0A0_0001;
        rom[16'h0101] = 32'hB0B0_0002;
        rom[16'h0102] = 32'hC0C0_0003;

        repeat (2) @(negedge clk);
        dut_if.start     = 1'b1;
        dut_if.load_len  = 12'd5;
        dut_if.acc_valid = 1'b1;
        dut_if.acc_ofmap = 32'hDEAD_BEEF;
        #1;
        check("rst ctrl", {27'h0, dut_if.busy, dut_if.acc_ready, dut_if.mem_ren,
                           dut_if.mem_wen, dut_if.finished}, 32'h0);
        check("rst wr_count", 32'(dut_if.wr_count), 32'h0);
        check("rst acc_data", dut_if.acc_data, 32'h0);
        check("rst addrs", {dut_if.mem_raddr, dut_if.mem_waddr}, 32'h0);
        check("rst wdata", dut_if.mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("post rst busy", 32'(dut_if.busy), 32'h0);

        // Zero-length start is ignored
        @(negedge clk);
        dut_if.start    = 1'b1;
        dut_if.src_base = 16'h1000;
        dut_if.dst_base = 16'h9000;
        #1;
        @(negedge clk);
        idle_inputs();
        #1;
        check("len0 busy1", 32'(dut_if.busy), 32'h0);
        @(negedge clk);
        #1;
        check("len0 busy2", 32'(dut_if.busy), 32'h0);

        // Three-word stream with results written from 0x0200
        clear_pattern();
`ifdef WRITEBACK_PACK_EN
        for (int c = 1; c <= 5; c++) begin
            vld_a[c] = 1'b1;
            dat_a[c] = {24'hABCDEF, 8'(c)};
        end
`else
        vld_a[2] = 1'b1; dat_a[2] = 32'h11;
        vld_a[3] = 1'b1; dat_a[3] = 32'h22;
`endif
        run_job(16'h0100, 3, 16'h0200, 6, 1'b0, 1);
`ifdef WRITEBACK_PACK_EN
        check("pack mem0", wr_mem[16'h0200], 32'h0403_0201);
        check("pack mem1", wr_mem[16'h0201], 32'h0000_0005);
`else
        check("mem 0x200", wr_mem[16'h0200], 32'h11);
        check("mem 0x201", wr_mem[16'h0201], 32'h22);
`endif
        check("dir wr_count", 32'(dut_if.wr_count), 32'd2);

        // Destination wraps from 0xFFFF to 0x0000
        clear_pattern();
`ifdef WRITEBACK_PACK_EN
        for (int c = 1; c <= 5; c++) begin
            vld_a[c] = 1'b1;
            dat_a[c] = 32'(8'h10 + 8'(c));
        end
`else
        vld_a[1] = 1'b1; dat_a[1] = 32'h5555_0001;
        vld_a[2] = 1'b1; dat_a[2] = 32'h5555_0002;
`endif
        run_job(16'h1200, 2, 16'hFFFF, 5, 1'b0, 2);
`ifdef WRITEBACK_PACK_EN
        check("wrap hi", wr_mem[16'hFFFF], 32'h1413_1211);
        check("wrap lo", wr_mem[16'h0000], 32'h0000_0015);
`else
        check("wrap hi", wr_mem[16'hFFFF], 32'h5555_0001);
        check("wrap lo", wr_mem[16'h0000], 32'h5555_0002);
`endif

        // Start during STREAM must not disturb the running job
        clear_pattern();
        for (int c = 1; c < 9; c++) begin
            vld_a[c] = 1'b1;
            dat_a[c] = 32'h3300_0000 + 32'(c);
        end
        run_job(16'h1400, 4, 16'hA000, 2, 1'b1, 3);

        for (int j = 0; j < 24; j++) begin
            clear_pattern();
            len  = $urandom_range(1, 6);
            src  = 16'h1000 + 16'($urandom_range(0, 16'h0FF0));
            dst  = 16'h8000 + 16'($urandom_range(0, 16'h7FFF));
            d    = $urandom_range(1, len + 5);
            poke = (len >= 2) && ($urandom_range(0, 1) == 1);
            for (int c = 0; c < len + 10; c++) begin
                vld_a[c] = ($urandom_range(0, 1) == 1);
                dat_a[c] = $urandom;
            end
            run_job(src, len, dst, d, poke, 10 + j);
        end

        // Reset in the second stream cycle aborts the job
        @(negedge clk);
        dut_if.start    = 1'b1;
        dut_if.src_base = 16'h1300;
        dut_if.load_len = 12'd5;
        dut_if.dst_base = 16'h9000;
        #1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        check("abort pre ready", 32'(dut_if.acc_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        dut_if.acc_valid = 1'b1;
        dut_if.acc_ofmap = 32'h7777_7777;
        dut_if.acc_done  = 1'b1;
        base = obs_wa.size();
        #1;
        check("abort rst outs", {28'h0, dut_if.acc_ready, dut_if.busy, dut_if.mem_wen,
                                 dut_if.finished}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort ready", 32'(dut_if.acc_ready), 32'h0);
        check("abort busy", 32'(dut_if.busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort fin %0d", i), 32'(dut_if.finished), 32'h0);
        end
        check("abort writes", obs_wa.size() - base, 32'h0);
        check("abort wr_count", 32'(dut_if.wr_count), 32'h0);
        idle_inputs();
        prev_wr = 0;

        // Long collect phase saturates wr_count
        clear_pattern();
        for (int c = 1; c < 4200; c++) begin
            vld_a[c] = 1'b1;
            dat_a[c] = 32'h7000_0000 + 32'(c);
        end
        run_job(16'h1800, 2, 16'h8000, 4200, 1'b0, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
